// File: rtl/gen_queue_pkg.sv
// gen_queue_pkg: shared types and constants for the queue stream adapter
package gen_queue_pkg;
  typedef enum logic {ARB_PUSH_PRI = 1'b0, ARB_POP_PRI = 1'b1} arb_st_type;
  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);
endpackage

// File: rtl/gen_skid_fifo2.sv
// gen_skid_fifo2: 2-entry register FIFO, head entry presented on rdata
module gen_skid_fifo2
  import gen_queue_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst,
  input  logic                  wr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  rd,
  output logic [DATA_W-1:0]     rdata,
  output logic [OBUF_CNT_W-1:0] cnt
);
  logic [DATA_W-1:0] e1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      rdata <= '0;
      e1    <= '0;
    end else if (sw_rst) begin
      cnt   <= '0;
      rdata <= '0;
      e1    <= '0;
    end else begin
      cnt <= cnt + OBUF_CNT_W'(wr) - OBUF_CNT_W'(rd);
      // a write into a 1-entry buffer that is also being read lands straight in the head
      if (rd) rdata <= (wr && cnt == OBUF_CNT_W'(1)) ? wdata : e1;
      else if (wr && cnt == '0) rdata <= wdata;
      if (wr && (rd ? cnt == OBUF_CNT_W'(2) : cnt == OBUF_CNT_W'(1))) e1 <= wdata;
    end
  end
endmodule

// File: rtl/gen_queue_stream_ctrl.sv
// gen_queue_stream_ctrl: valid/ready stream adapter around a single-port push/pop queue
module gen_queue_stream_ctrl
  import gen_queue_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 100,
  parameter int SIM_DLY = 1,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst,
  input  logic [DEPTH_W-1:0] cnfg_depth,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               q_push,
  output logic               q_pop,
  output logic [DATA_W-1:0]  q_wdata,
  input  logic [DATA_W-1:0]  q_rdata,
  output logic [DEPTH_W-1:0] q_cnt
);
  arb_st_type            arb_st;
  logic                  rd_pend, out_fire, pop_elig, push_fire;
  logic [OBUF_CNT_W-1:0] obuf_cnt;
  logic [2:0]            occ;
  always_comb begin
    out_valid = obuf_cnt != '0;
    out_fire  = out_valid && out_ready;
    // words already committed to the output buffer once this cycle settles
    occ       = 3'(obuf_cnt) + 3'(rd_pend) - 3'(out_fire);
    pop_elig  = q_cnt != '0 && occ < 3'(OBUF_DEPTH);
    in_ready  = !sw_rst && q_cnt < cnfg_depth && (arb_st == ARB_PUSH_PRI || !pop_elig);
    push_fire = in_valid && in_ready;
    q_push    = push_fire;
    q_pop     = !sw_rst && pop_elig && !push_fire;
    q_wdata   = in_data;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_cnt   <= '0;
      rd_pend <= 1'b0;
      arb_st  <= ARB_PUSH_PRI;
    end else if (sw_rst) begin
      q_cnt   <= '0;
      rd_pend <= 1'b0;
      arb_st  <= ARB_PUSH_PRI;
    end else begin
      q_cnt   <= q_cnt + DEPTH_W'(q_push) - DEPTH_W'(q_pop);
      rd_pend <= q_pop;
      arb_st  <= q_push ? ARB_POP_PRI : q_pop ? ARB_PUSH_PRI : arb_st;
      assert (obuf_cnt <= OBUF_CNT_W'(OBUF_DEPTH))
        else $error("output buffer overflow (queue sim delay %0d)", SIM_DLY);
    end
  end
  gen_skid_fifo2 #(.DATA_W(DATA_W)) u_obuf (
    .clk   (clk),
    .rstn  (rstn),
    .sw_rst(sw_rst),
    .wr    (rd_pend),
    .wdata (q_rdata),
    .rd    (out_fire),
    .rdata (out_data),
    .cnt   (obuf_cnt)
  );
endmodule

// File: tb/tb_gen_queue_stream_ctrl.sv
// tb_gen_queue_stream_ctrl: directed vector table plus multi-cycle sequences with an ordering scoreboard
module tb_gen_queue_stream_ctrl;
  localparam int DW = 8, DEPTH = 100, DEPTH_W = $clog2(DEPTH + 1);
  logic clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DEPTH_W-1:0] cnfg_depth = 7'd4;
  logic [DW-1:0] in_data = '0, q_rdata = '0;
  logic in_ready, out_valid, q_push, q_pop;
  logic [DW-1:0] out_data, q_wdata;
  logic [DEPTH_W-1:0] q_cnt;

  gen_queue_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SIM_DLY(1)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .cnfg_depth(cnfg_depth),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .q_push(q_push), .q_pop(q_pop), .q_wdata(q_wdata), .q_rdata(q_rdata), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  // behavioural single-port queue with 1-clk read latency
  logic [DW-1:0] mq[$];
  always @(posedge clk) begin
    if (!rstn || sw_rst) mq.delete();
    else begin
      if (q_pop) q_rdata <= (mq.size() != 0) ? mq.pop_front() : 8'hEE;
      if (q_push) mq.push_back(q_wdata);
    end
  end

  int checks = 0, failures = 0, n_out = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_out = '0, prev_data = '0;
  logic prev_hold = 1'b0, mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rstn && prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      chk("push_pop_excl", 32'(q_push & q_pop), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0h expected no word", out_data);
        end else chk("out_order", 32'(out_data), 32'(exp_q.pop_front()));
        last_out = out_data;
        n_out++;
      end
      if (rstn && !sw_rst && in_valid && in_ready) exp_q.push_back(in_data);
      if (!rstn || sw_rst) exp_q.delete();
      prev_hold = rstn && !sw_rst && out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // flags = {in_ready, q_push, q_pop, out_valid}; od compared only when out_valid expected
  typedef struct {
    logic iv; logic [DW-1:0] id; logic ordy;
    logic [3:0] flags; logic [DW-1:0] od; logic [DEPTH_W-1:0] cnt;
  } vec_t;
  vec_t tbl[13];

  logic [DW-1:0] words[200];
  int acc, cyc, alt_err, k;
  logic fire, pp;

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 4'b1100, 8'h00, 7'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'b0010, 8'h00, 7'd1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 4'b1000, 8'h00, 7'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 4'b1001, 8'hA5, 7'd0};
    tbl[4]  = '{1'b1, 8'h11, 1'b1, 4'b1100, 8'h00, 7'd0};
    tbl[5]  = '{1'b1, 8'h22, 1'b1, 4'b0010, 8'h00, 7'd1};
    tbl[6]  = '{1'b1, 8'h22, 1'b1, 4'b1100, 8'h00, 7'd0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 4'b0011, 8'h11, 7'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'b1000, 8'h00, 7'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'b1001, 8'h22, 7'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 4'b1001, 8'h22, 7'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 4'b1001, 8'h22, 7'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 4'b1000, 8'h00, 7'd0};
    foreach (words[i]) words[i] = 8'($urandom);

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_q_cnt", 32'(q_cnt), 32'd0);
    chk("rst_q_pop", 32'(q_pop), 32'd0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk) chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].flags[3]));
      chk($sformatf("vec%0d_q_push", i), 32'(q_push), 32'(tbl[i].flags[2]));
      chk($sformatf("vec%0d_q_pop", i), 32'(q_pop), 32'(tbl[i].flags[1]));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].flags[0]));
      chk($sformatf("vec%0d_q_cnt", i), 32'(q_cnt), 32'(tbl[i].cnt));
      if (tbl[i].flags[0]) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();

    // fill against a stalled output: 4 in the queue plus 2 in the buffer
    acc = 0;
    repeat (20) begin
      in_valid = 1'b1; in_data = 8'(acc + 1);
      @(negedge clk) fire = in_ready;
      step();
      if (fire) acc++;
    end
    chk("fill_accepted", 32'(acc), 32'd6);
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_q_cnt", 32'(q_cnt), 32'd4);
    step();
    in_valid = 1'b0; n_out = 0; out_ready = 1'b1;
    drain("fill_drain");
    chk("fill_n_out", 32'(n_out), 32'd6);
    chk("fill_last", 32'(last_out), 32'd6);

    // both sides saturated
    acc = 0; cyc = 0; alt_err = 0; pp = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (acc < 50 && cyc < 300) begin
      in_data = 8'(8'h80 + acc);
      @(negedge clk);
      fire = in_ready;
      if (cyc > 0 && (q_push == pp || q_push == q_pop)) alt_err++;
      pp = q_push;
      step();
      if (fire) acc++;
      cyc++;
    end
    chk("sat_words", 32'(acc), 32'd50);
    chk("sat_alternate", 32'(alt_err), 32'd0);
    in_valid = 1'b0;
    drain("sat_drain");

    // random valid and ready
    acc = 0; cyc = 0;
    while (acc < 200 && cyc < 3000) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_data = words[acc];
      @(negedge clk) fire = in_valid && in_ready;
      step();
      if (fire) acc++;
      cyc++;
    end
    chk("rand_words", 32'(acc), 32'd200);
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain");

    // soft reset while a queue read is in flight
    out_ready = 1'b0; acc = 0;
    repeat (20) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + acc);
      @(negedge clk) fire = in_ready;
      step();
      if (fire) acc++;
    end
    out_ready = 1'b1;
    @(negedge clk) chk("srst_pre_pop", 32'(q_pop), 32'd1);
    step();
    out_ready = 1'b0; sw_rst = 1'b1;
    @(negedge clk);
    chk("srst_q_cnt_pre", 32'(q_cnt), 32'd3);
    chk("srst_in_ready", 32'(in_ready), 32'd0);
    chk("srst_q_push", 32'(q_push), 32'd0);
    chk("srst_q_pop", 32'(q_pop), 32'd0);
    step();
    sw_rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("srst_out_valid", 32'(out_valid), 32'd0);
    chk("srst_q_cnt", 32'(q_cnt), 32'd0);
    step();
    repeat (3) begin
      @(negedge clk) chk("srst_no_stale", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    @(negedge clk) chk("srst_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    chk("srst_5a_valid", 32'(out_valid), 32'd1);
    chk("srst_5a_data", 32'(out_data), 32'h5A);
    step();

    // asynchronous reset in the middle of traffic
    in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h70;
    repeat (4) step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_q_cnt", 32'(q_cnt), 32'd0);
    chk("arst_q_pop", 32'(q_pop), 32'd0);
    in_valid = 1'b0; cnfg_depth = 7'd4;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk) chk("arst_in_ready", 32'(in_ready), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
